// File: rtl/bcd_formatter.sv
// Purpose: converts a 14-bit binary value to four BCD digits with leading-zero blanking and an overflow marker, plus a free-running display-scan tick.
// Latency: fixed 15 cycles from an accepted start to the done pulse, independent of value.
// Backpressure: none; a start while busy is dropped, not queued. Outputs hold until the next done.
module bcd_formatter #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] value,
  input  logic        lz_en,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  blank,
  output logic        scan_tick
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t      state;
  logic [13:0] shreg;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  iter;
  logic        lz_q;
  logic        ovf_q;
  logic [3:0]  blank_nxt;
  logic [SW-1:0] scan_cnt;
  logic [SW-1:0] scan_nxt;

  // Double-dabble correction: bump every nibble of 5 or more by 3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask chains down from the thousands digit; units digit is never blanked.
  always_comb begin
    blank_nxt    = 4'b0000;
    blank_nxt[3] = lz_q & (bcd[15:12] == 4'd0);
    blank_nxt[2] = blank_nxt[3] & (bcd[11:8] == 4'd0);
    blank_nxt[1] = blank_nxt[2] & (bcd[7:4] == 4'd0);
  end

  // Conversion FSM: capture, 14 add-3/shift iterations, then register the display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      iter     <= '0;
      lz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      digit0   <= 4'd0;
      digit1   <= 4'd0;
      digit2   <= 4'd0;
      digit3   <= 4'd0;
      blank    <= 4'b1111;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= value;
            bcd   <= '0;
            iter  <= '0;
            lz_q  <= lz_en;
            ovf_q <= (value > 14'd9999);
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          bcd   <= {bcd_adj[14:0], shreg[13]};
          shreg <= {shreg[12:0], 1'b0};
          iter  <= iter + 4'd1;
          if (iter == 4'd13) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          if (ovf_q) begin
            digit0 <= 4'hE;
            digit1 <= 4'hE;
            digit2 <= 4'hE;
            digit3 <= 4'hE;
            blank  <= 4'b0000;
          end else begin
            digit0 <= bcd[3:0];
            digit1 <= bcd[7:4];
            digit2 <= bcd[11:8];
            digit3 <= bcd[15:12];
            blank  <= blank_nxt;
          end
          overflow <= ovf_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign scan_nxt = (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SW'(1);

  // Free-running scan divider; the tick register mirrors "counter at its last value".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b0;
    end else begin
      scan_cnt  <= scan_nxt;
      scan_tick <= (scan_nxt == SCAN_LAST);
    end
  end

endmodule

// File: doc/bcd_formatter.md
BCD_FORMATTER -- requirements
Module: bcd_formatter

Interface
REQ-001 Parameter: SCAN_DIV, 50000, clock cycles per scan_tick pulse (legal range 2..2^20).
REQ-002 Port: clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  conversion request, sampled only in IDLE.
REQ-005 Port: value  input  14  unsigned binary value to convert, captured on an accepted start.
REQ-006 Port: lz_en  input  1  leading-zero suppression enable, captured on an accepted start.
REQ-007 Port: busy  output  1  high while a conversion is in progress.
REQ-008 Port: done  output  1  single-cycle pulse when new display outputs are valid.
REQ-009 Port: overflow  output  1  high when the last captured value was above 9999.
REQ-010 Port: digit0, digit1, digit2, digit3  output  4 each  units, tens, hundreds and thousands digit.
REQ-011 Port: blank  output  4  per-digit blank mask; bit i blanks digit i.
REQ-012 Port: scan_tick  output  1  single-cycle display-scan enable pulse.

Function
REQ-013 The block SHALL implement a state machine with three states: IDLE, CONVERT and UPDATE.
REQ-014 IDLE behaviour:
- start=1 at a rising edge E0 SHALL capture value and lz_en.
- The same edge SHALL load the 14-bit shift register with value, clear the 16-bit BCD register, clear the iteration counter, set busy=1 and enter CONVERT.
REQ-015 CONVERT behaviour:
- Each edge SHALL first add 3 to every BCD nibble that is 5 or greater.
- It SHALL then shift {BCD, shift register} left by one bit.
- It SHALL increment the iteration counter.
- After the 14th iteration, at edge E14, it SHALL enter UPDATE.
REQ-016 UPDATE behaviour, at edge E15:
- digit0..digit3, blank and overflow SHALL be registered.
- done SHALL be set to 1 for exactly one cycle.
- busy SHALL be set to 0 and the state SHALL return to IDLE.
- Start-to-done latency is therefore fixed at 15 cycles for every value.
REQ-017 A start asserted while busy=1 SHALL be ignored; no request is queued.
REQ-018 A start asserted in the cycle where done=1 SHALL be accepted, since the state is IDLE.
REQ-019 Changes on value or lz_en after the capture edge SHALL NOT affect the result in progress.
REQ-020 Overflow handling for a captured value above 9999:
- overflow SHALL be 1.
- All four digits SHALL be 4'hE.
- blank SHALL be 4'b0000.
- Latency SHALL be unchanged.
REQ-021 For a captured value of 9999 or below, overflow SHALL be 0 and digit0..3 SHALL be the decimal digits of value.
REQ-022 Blank mask with lz_en=1:
- blank[3] = (digit3==0).
- blank[2] = blank[3] & (digit2==0).
- blank[1] = blank[2] & (digit1==0).
- blank[0] = 0.
REQ-023 Blank mask with lz_en=0: blank SHALL be 4'b0000.
REQ-024 digit0..3, blank and overflow SHALL hold their values between done pulses.
REQ-025 scan_tick counter:
- A free-running counter SHALL count 0..SCAN_DIV-1 and wrap to 0.
- scan_tick SHALL be 1 only when the counter equals SCAN_DIV-1.
- The counter SHALL run independently of the conversion state.
REQ-026 All outputs SHALL be driven directly from registers.

Reset
REQ-027 Asserting reset SHALL immediately force:
- state=IDLE, busy=0, done=0, overflow=0.
- digit0..3=0 and blank=4'b1111 (display dark).
- scan counter=0 and scan_tick=0.
REQ-028 Reset asserted during CONVERT or UPDATE SHALL abort the conversion; no done pulse follows, and outputs remain at reset values until a later completed conversion.
REQ-029 After reset is released, the first scan_tick SHALL occur at the (SCAN_DIV)th rising edge.

Verification
REQ-030 Start with value=1234 and lz_en=1 -> done exactly 15 cycles after start; digits 4,3,2,1; blank=0000; overflow=0.
REQ-031 value=7 with lz_en=1 -> digits 7,0,0,0 and blank=1110; value=7 with lz_en=0 -> blank=0000.
REQ-032 value=0 with lz_en=1 -> digit0=0 and blank=1110; value=9999 -> digits 9,9,9,9 and blank=0000.
REQ-033 value=10000 -> overflow=1; digits E,E,E,E; blank=0000; done after 15 cycles.
REQ-034 Start pulsed again 5 cycles into a conversion -> ignored, and the original result is delivered.
- Then assert reset 7 cycles into a new conversion -> busy drops immediately, no done pulse, blank=1111.
REQ-035 With SCAN_DIV=4 -> scan_tick is high on every 4th cycle; reset mid-count restarts the period from 0.
